// File: rtl/alu_pkg.sv
// Shared op codes and shifter mode encoding for the alu_32 execute-stage ALU.
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_AND  = 4'b0000;
  localparam alu_op_t ALU_OR   = 4'b0001;
  localparam alu_op_t ALU_ADD  = 4'b0010;
  localparam alu_op_t ALU_XOR  = 4'b0011;
  localparam alu_op_t ALU_SUB  = 4'b0100;
  localparam alu_op_t ALU_NOR  = 4'b0101;
  localparam alu_op_t ALU_SLT  = 4'b0110;
  localparam alu_op_t ALU_SLTU = 4'b0111;
  localparam alu_op_t ALU_SLL  = 4'b1000;
  localparam alu_op_t ALU_SRL  = 4'b1001;
  localparam alu_op_t ALU_SRA  = 4'b1010;
  localparam alu_op_t ALU_LUI  = 4'b1011;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_t;

endpackage

// File: rtl/alu_32_if.sv
// Operand/result bundle between the execute stage and alu_32.
// The ovf signal exists only when ALU_OVERFLOW_EN is defined.
interface alu_32_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  alu_op_t          op;
  logic [WIDTH-1:0] result;
  logic             zero;
`ifdef ALU_OVERFLOW_EN
  logic             ovf;

  modport master (output a, output b, output op, input result, input zero, input ovf);
  modport slave  (input a, input b, input op, output result, output zero, output ovf);
`else
  modport master (output a, output b, output op, input result, input zero);
  modport slave  (input a, input b, input op, output result, output zero);
`endif

endinterface

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for SLL/SRL/SRA; only the low $clog2(WIDTH) bits
// of the shift amount are seen here.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  input  shift_t           mode,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = a;
    case (mode)
      SH_SLL:  y = a << shamt;
      SH_SRL:  y = a >> shamt;
      SH_SRA:  y = $unsigned($signed(a) >>> shamt);
      default: y = a;
    endcase
  end

endmodule

// File: rtl/alu_32.sv
// Registered integer ALU (1-cycle latency) with zero flag for branch-equal.
// Define ALU_OVERFLOW_EN to add the registered signed-overflow flag ovf.
module alu_32
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic   clk,
  input logic   rst,
  alu_32_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] shift_y;
  logic [WIDTH-1:0] next_result;
  logic             is_sub;
  logic             slt_s;
  logic             slt_u;
  shift_t           shift_mode;

  logic [WIDTH-1:0] result_q;
  logic             zero_q;

  // One adder serves ADD and SUB: subtraction is a + ~b + 1.
  assign is_sub = (bus.op == ALU_SUB);
  assign b_eff  = is_sub ? ~bus.b : bus.b;
  assign sum    = bus.a + b_eff + {{(WIDTH-1){1'b0}}, is_sub};
  assign slt_s  = ($signed(bus.a) < $signed(bus.b));
  assign slt_u  = (bus.a < bus.b);

  always_comb begin
    shift_mode = SH_SLL;
    if (bus.op == ALU_SRL) shift_mode = SH_SRL;
    else if (bus.op == ALU_SRA) shift_mode = SH_SRA;
  end

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .a     (bus.a),
    .shamt (bus.b[SHW-1:0]),
    .mode  (shift_mode),
    .y     (shift_y)
  );

  always_comb begin
    next_result = '0;
    case (bus.op)
      ALU_AND:  next_result = bus.a & bus.b;
      ALU_OR:   next_result = bus.a | bus.b;
      ALU_ADD:  next_result = sum;
      ALU_XOR:  next_result = bus.a ^ bus.b;
      ALU_SUB:  next_result = sum;
      ALU_NOR:  next_result = ~(bus.a | bus.b);
      ALU_SLT:  next_result = {{(WIDTH-1){1'b0}}, slt_s};
      ALU_SLTU: next_result = {{(WIDTH-1){1'b0}}, slt_u};
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  next_result = shift_y;
      ALU_LUI:  next_result = bus.b << 16;
      default:  next_result = '0;
    endcase
  end

  // zero is taken from the value being registered, so it always matches result.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= next_result;
      zero_q   <= (next_result == '0);
    end
  end

  assign bus.result = result_q;
  assign bus.zero   = zero_q;

`ifdef ALU_OVERFLOW_EN
  logic ovf_next;
  logic ovf_q;

  // With b already inverted for SUB, both cases reduce to the ADD overflow rule.
  assign ovf_next = ((bus.op == ALU_ADD) || is_sub) &&
                    (bus.a[MSB] == b_eff[MSB]) && (sum[MSB] != bus.a[MSB]);

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_next;
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_alu_32.sv
// Self-checking bench for alu_32: directed vector table, reset corner cases and
// randomized operations against an arithmetic reference model.
module tb_alu_32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_32_if #(.WIDTH(32)) alu_bus ();

  alu_32 #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (alu_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_result;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk_vec(string name, logic [3:0] op, logic [31:0] a,
                                  logic [31:0] b, logic [31:0] r, logic z);
    vec_t v;
    v.name = name;
    v.op = op;
    v.a = a;
    v.b = b;
    v.exp_result = r;
    v.exp_zero = z;
    return v;
  endfunction

  // Reference model derived from the op table using plain integer arithmetic.
  function automatic logic [31:0] model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    longint sa;
    longint sb;
    int     sh;
    logic [31:0] fill;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return 32'(longint'(a) + longint'(b));
      4'd3:  return a ^ b;
      4'd4:  return 32'(longint'(a) - longint'(b));
      4'd5:  return ~(a | b);
      4'd6:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd7:  return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      4'd8:  return 32'(longint'(a) * (64'd1 << sh));
      4'd9:  return 32'(longint'(a) / (64'd1 << sh));
      4'd10: begin
        fill = (a[31] && sh != 0) ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
        return (a >> sh) | fill;
      end
      4'd11: return 32'(longint'(b) * 65536);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_ovf(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    longint sa;
    longint sb;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 4'd2) r = sa + sb;
    else if (op == 4'd4) r = sa - sb;
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    alu_bus.op = op;
    alu_bus.a = a;
    alu_bus.b = b;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] exp_r, input logic exp_z);
    checks++;
    if (alu_bus.result !== exp_r || alu_bus.zero !== exp_z) begin
      errors++;
      $display("[TB] FAIL %s: result=%h zero=%b, expected result=%h zero=%b",
               name, alu_bus.result, alu_bus.zero, exp_r, exp_z);
    end
  endtask

`ifdef ALU_OVERFLOW_EN
  task automatic checkOvf(input string name, input logic exp_o);
    checks++;
    if (alu_bus.ovf !== exp_o) begin
      errors++;
      $display("[TB] FAIL %s: ovf=%b, expected ovf=%b", name, alu_bus.ovf, exp_o);
    end
  endtask
`endif

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] exp_r;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    alu_bus.op = 4'd0;
    alu_bus.a = 32'd0;
    alu_bus.b = 32'd0;

    vecs.push_back(mk_vec("and",      4'b0000, 32'h0000_0C0C, 32'h0000_ABCD, 32'h0000_080C, 1'b0));
    vecs.push_back(mk_vec("or",       4'b0001, 32'h0000_0C0C, 32'h0000_ABCD, 32'h0000_AFCD, 1'b0));
    vecs.push_back(mk_vec("nor",      4'b0101, 32'h0000_0C0C, 32'h0000_ABCD, 32'hFFFF_5032, 1'b0));
    vecs.push_back(mk_vec("add",      4'b0010, 32'h0000_0C0C, 32'h0000_ABCD, 32'h0000_B7D9, 1'b0));
    vecs.push_back(mk_vec("sub",      4'b0100, 32'h0000_0C0C, 32'h0000_ABCD, 32'hFFFF_603F, 1'b0));
    vecs.push_back(mk_vec("slt",      4'b0110, 32'h0000_0C0C, 32'h0000_ABCD, 32'h0000_0001, 1'b0));
    vecs.push_back(mk_vec("slt_min",  4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0));
    vecs.push_back(mk_vec("sltu_min", 4'b0111, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b1));
    vecs.push_back(mk_vec("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1));
    vecs.push_back(mk_vec("sll",      4'b1000, 32'h8000_0000, 32'h0000_0004, 32'h0000_0000, 1'b1));
    vecs.push_back(mk_vec("srl",      4'b1001, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0));
    vecs.push_back(mk_vec("sra",      4'b1010, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0));
    vecs.push_back(mk_vec("undef",    4'b1111, 32'h8000_0000, 32'h0000_0004, 32'h0000_0000, 1'b1));
    vecs.push_back(mk_vec("xor",      4'b0011, 32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000, 1'b0));
    vecs.push_back(mk_vec("sll_by0",  4'b1000, 32'h1234_5678, 32'hFFFF_FFE0, 32'h1234_5678, 1'b0));
    vecs.push_back(mk_vec("sra_by31", 4'b1010, 32'h8000_0000, 32'h0000_003F, 32'hFFFF_FFFF, 1'b0));
    vecs.push_back(mk_vec("lui",      4'b1011, 32'h0000_0000, 32'h0001_ABCD, 32'hABCD_0000, 1'b0));

    // Reset state, then SUB of equal operands must raise zero.
    @(negedge clk);
    rst = 1'b1;
    alu_bus.op = 4'b0010;
    alu_bus.a = 32'h1111_1111;
    alu_bus.b = 32'h2222_2222;
    @(posedge clk);
    #1;
    checkOutput("reset", 32'd0, 1'b1);
`ifdef ALU_OVERFLOW_EN
    checkOvf("reset_ovf", 1'b0);
`endif
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'b0100, 32'h0000_ABCD, 32'h0000_ABCD);
    checkOutput("sub_equal", 32'd0, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      checkOutput(vecs[i].name, vecs[i].exp_result, vecs[i].exp_zero);
    end

    // zero must follow the new result, not the previous one.
    applyStimulus(4'b0010, 32'h0000_0001, 32'h0000_0001);
    checkOutput("b2b_nonzero", 32'd2, 1'b0);
    applyStimulus(4'b0000, 32'h0000_0001, 32'h0000_0002);
    checkOutput("b2b_zero", 32'd0, 1'b1);

`ifdef ALU_OVERFLOW_EN
    applyStimulus(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    checkOutput("add_ovf", 32'h8000_0000, 1'b0);
    checkOvf("add_ovf_flag", 1'b1);
    applyStimulus(4'b0100, 32'h8000_0000, 32'h0000_0001);
    checkOvf("sub_ovf_flag", 1'b1);
`endif

    // Reset asserted with a live op discards the op.
    @(negedge clk);
    rst = 1'b1;
    alu_bus.op = 4'b0010;
    alu_bus.a = 32'h7FFF_FFFF;
    alu_bus.b = 32'h0000_0001;
    @(posedge clk);
    #1;
    checkOutput("rst_midstream", 32'd0, 1'b1);
`ifdef ALU_OVERFLOW_EN
    checkOvf("rst_midstream_ovf", 1'b0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: ra = 32'h8000_0000;
        1: rb = ra;
        2: ra = 32'h7FFF_FFFF;
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      applyStimulus(rop, ra, rb);
      exp_r = model(rop, ra, rb);
      checkOutput($sformatf("rand%0d_op%0d", i, rop), exp_r, exp_r == 32'd0);
`ifdef ALU_OVERFLOW_EN
      checkOvf($sformatf("rand%0d_ovf", i), model_ovf(rop, ra, rb));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

`ifndef ALU_OVERFLOW_EN
  // Keeps the overflow model exercised in builds without the flag.
  initial begin
    if (model_ovf(4'd2, 32'h7FFF_FFFF, 32'd1) !== 1'b1)
      $display("[TB] overflow model self-test inconsistent");
  end
`endif

endmodule
